serial_alu: RTL and testbench
=============================

# serial_alu

Bit-serial ALU that processes two WIDTH-bit operands one bit per cycle, LSB first, through a single one-bit add/sub/and/or datapath. It is the control and sequencing side of the one-bit ALU slice. It latches the operands, steps them through the slice, propagates carry between cycles, assembles the result word and produces NZCV flags. It is a low-area alternative to the parallel ALU in the lab datapath.

## Interface
- WIDTH, 32, operand and result width in bits (≥2)
- clk  input  1  rising-edge clock
- reset  input  1  synchronous, active-high reset
- start  input  1  request an operation; honored only when busy=0
- a  input  WIDTH  operand A, sampled on accepted start
- b  input  WIDTH  operand B, sampled on accepted start
- ALUControl  input  2  00 ADD, 01 SUB (A−B), 10 AND, 11 OR; sampled on accepted start
- busy  output  1  operation in progress
- done  output  1  one-cycle pulse: Result/ALUFlags valid
- Result  output  WIDTH  result word, held until next accepted start
- ALUFlags  output  4  {N,Z,C,V}, held with Result

## Operation
- States: IDLE, SHIFT, DONE.
- IDLE: busy=0. When start=1, latch a, b and ALUControl into shift registers, clear bit counter, set carry register = ALUControl[0], then go to SHIFT.
- SHIFT: busy=1. Each cycle the slice operates on bit 0 of the A and B shift registers:
  - B is inverted when ALUControl[0]=1.
  - Carry-in comes from the carry register.
  - The slice result bit shifts into Result from the MSB side. The operand registers shift right, the carry register updates, and the counter increments.
- After bit WIDTH−1 is processed, go to DONE.
- DONE: busy=0, done=1 for exactly one cycle, flags registered. Then go to IDLE.
- start in DONE is ignored. start during SHIFT is ignored. Input changes while busy have no effect.
- Flags:
  - N = Result[WIDTH−1].
  - Z = (Result == 0).
  - C = carry out of the MSB for ADD and SUB. For SUB, C=1 means no borrow.
  - V = (A[msb] == B'[msb]) && (Result[msb] != A[msb]), where B' is the selected (possibly inverted) B.
  - C and V are 0 for AND and OR.
- Arithmetic is modulo 2^WIDTH. No saturation.

## Timing
- Reset values: busy=0, done=0, Result=0, ALUFlags=0, state IDLE, counter 0, carry 0.
- Start accepted at rising edge t (start=1, state IDLE) gives:
  - busy=1 from edge t through edge t+WIDTH;
  - done=1 and busy=0 after edge t+WIDTH+1.
- Total latency is WIDTH+1 cycles (33 for WIDTH=32).
- Back-to-back operation: the earliest next accepted start is the edge after done drops, so the throughput bound is one op per WIDTH+2 cycles.
- Reset asserted mid-operation:
  - the in-flight operation is abandoned and done is never asserted for it;
  - the next cycle shows the reset values.
- Reset and start in the same cycle: reset wins and start is dropped.
- Result and ALUFlags change only at the DONE transition or on reset. They are never partially updated as seen at the outputs; bits are assembled in an internal register.

## Configuration
- SERIAL_ALU_FLAGS_EN defined: ALUFlags are computed as above and registered at DONE.
- Not defined:
  - ALUFlags is tied to 4'b0000;
  - no flag logic or carry-out capture is synthesized;
  - Result and timing are unchanged.

## Test plan
All scenarios use WIDTH=32 and SERIAL_ALU_FLAGS_EN defined unless stated.
- ADD 0x7FFFFFFF + 0x00000001 -> Result=0x80000000, ALUFlags=1001, done exactly 33 cycles after the start edge, busy high for 32 cycles.
- SUB 5 − 5 -> Result=0x00000000, ALUFlags=0110. SUB 3 − 5 -> Result=0xFFFFFFFE, ALUFlags=1000.
- AND 0xF0F0F0F0 & 0xFF00FF00 -> 0xF000F000, ALUFlags=1000. OR of the same operands -> 0xFFF0FFF0, ALUFlags=1000.
- Start ADD 1+1, then pulse start with different operands and change a/b at cycle 10 while busy -> Result=0x00000002 and a single done pulse. The second request is ignored.
- Assert reset at cycle 15 of SUB 0 − 1 -> next cycle busy=0, done=0, Result=0, ALUFlags=0, and no done pulse follows. A following ADD 2+3 -> Result=5.
- Macro undefined, ADD 0xFFFFFFFF + 1 -> Result=0x00000000, ALUFlags=0000, latency 33.

Source files
------------

// File: rtl/serial_alu_if.sv
// Operand/result bundle between a requester and the bit-serial ALU.
// state mirrors the ALU's FSM encoding (0 idle, 1 shift, 2 done) for observation.
interface serial_alu_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [1:0]       ALUControl;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] Result;
    logic [3:0]       ALUFlags;
    logic [1:0]       state;

    // start is a request, honored only while busy=0 and the ALU is idle; done is a
    // one-cycle pulse marking Result/ALUFlags valid, and both hold until the next accepted start.
    modport master (
        output start, a, b, ALUControl,
        input  busy, done, Result, ALUFlags, state
    );

    modport slave (
        input  start, a, b, ALUControl,
        output busy, done, Result, ALUFlags, state
    );
endinterface

// File: rtl/serial_alu.sv
// Bit-serial ALU: steps two WIDTH-bit operands LSB first through a one-bit add/sub/and/or slice.
// Define SERIAL_ALU_FLAGS_EN to compute NZCV flags; otherwise ALUFlags reads 4'b0000.
module serial_alu #(
    parameter int WIDTH = 32
) (
    input logic        clk,
    input logic        reset,
    serial_alu_if.slave bus
);
    localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic [WIDTH-1:0] res_sh;
    logic [WIDTH-1:0] result_q;
    logic [1:0]       op;
    logic [CW-1:0]    cnt;
    logic             carry;
    logic             busy_q;
    logic             done_q;
    logic             bsel;
    logic             slice_bit;
    logic             slice_cout;

`ifdef SERIAL_ALU_FLAGS_EN
    logic       a_msb;
    logic       bs_msb;
    logic [3:0] flags_q;
    logic       arith;
    assign arith = ~op[1];
`endif

    // Logic ops use raw B; only arithmetic sees the inverted operand.
    always_comb begin
        bsel       = b_sh[0] ^ op[0];
        slice_bit  = 1'b0;
        slice_cout = carry;
        case (op)
            2'b00, 2'b01: begin
                slice_bit  = a_sh[0] ^ bsel ^ carry;
                slice_cout = (a_sh[0] & bsel) | (carry & (a_sh[0] ^ bsel));
            end
            2'b10:   slice_bit = a_sh[0] & b_sh[0];
            default: slice_bit = a_sh[0] | b_sh[0];
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            a_sh     <= '0;
            b_sh     <= '0;
            res_sh   <= '0;
            result_q <= '0;
            op       <= 2'b00;
            cnt      <= '0;
            carry    <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
`ifdef SERIAL_ALU_FLAGS_EN
            a_msb    <= 1'b0;
            bs_msb   <= 1'b0;
            flags_q  <= 4'b0000;
`endif
        end else begin
            done_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        a_sh   <= bus.a;
                        b_sh   <= bus.b;
                        op     <= bus.ALUControl;
                        cnt    <= '0;
                        carry  <= bus.ALUControl[0];
                        busy_q <= 1'b1;
                        state  <= SHIFT;
`ifdef SERIAL_ALU_FLAGS_EN
                        a_msb  <= bus.a[WIDTH-1];
                        bs_msb <= bus.b[WIDTH-1] ^ bus.ALUControl[0];
`endif
                    end
                end
                SHIFT: begin
                    a_sh   <= a_sh >> 1;
                    b_sh   <= b_sh >> 1;
                    res_sh <= {slice_bit, res_sh[WIDTH-1:1]};
                    carry  <= slice_cout;
                    cnt    <= cnt + 1'b1;
                    if (cnt == LAST) begin
                        busy_q <= 1'b0;
                        state  <= DONE;
                    end
                end
                DONE: begin
                    done_q   <= 1'b1;
                    result_q <= res_sh;
`ifdef SERIAL_ALU_FLAGS_EN
                    flags_q  <= {res_sh[WIDTH-1],
                                 res_sh == '0,
                                 arith & carry,
                                 arith & (a_msb == bs_msb) & (res_sh[WIDTH-1] != a_msb)};
`endif
                    state    <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.busy   = busy_q;
    assign bus.done   = done_q;
    assign bus.Result = result_q;
    assign bus.state  = state;
`ifdef SERIAL_ALU_FLAGS_EN
    assign bus.ALUFlags = flags_q;
`else
    assign bus.ALUFlags = 4'b0000;
`endif
endmodule

// File: tb/tb_serial_alu.sv
// Directed bench for serial_alu: expected {Result,ALUFlags} go into a queue, a monitor checks each done.
// Flag expectations follow whether SERIAL_ALU_FLAGS_EN is defined for the build.
module tb_serial_alu;
    localparam int W = 32;

    logic clk;
    logic reset;
    int   checks;
    int   fails;
    int   cyc;
    int   done_cnt;
    logic [W+3:0] exp_q[$];

    serial_alu_if #(.WIDTH(W)) bus ();
    serial_alu #(.WIDTH(W)) dut (.clk(clk), .reset(reset), .bus(bus));

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [3:0] fl(input logic [3:0] f);
`ifdef SERIAL_ALU_FLAGS_EN
        return f;
`else
        return 4'b0000 & f;
`endif
    endfunction

    // monitor / scoreboard
    always @(negedge clk) begin
        if (!reset && bus.done) begin
            logic [W+3:0] e;
            done_cnt++;
            if (exp_q.size() == 0) begin
                checks++;
                fails++;
                $display("FAIL unexpected_done: got done with empty queue, expected none");
            end else begin
                e = exp_q.pop_front();
                check("result", {32'h0, bus.Result}, {32'h0, e[W+3:4]});
                check("flags", {60'h0, bus.ALUFlags}, {60'h0, e[3:0]});
            end
        end
    end

    // drivers
    task automatic issue(input logic [1:0] op, input logic [W-1:0] av, input logic [W-1:0] bv);
        bus.start      = 1'b1;
        bus.ALUControl = op;
        bus.a          = av;
        bus.b          = bv;
        @(negedge clk);
        bus.start = 1'b0;
    endtask

    // Runs one op, optionally disturbing the inputs while busy, and checks latency/busy length.
    task automatic run_op(input logic [1:0] op, input logic [W-1:0] av, input logic [W-1:0] bv,
                          input logic [W-1:0] er, input logic [3:0] ef, input bit disturb);
        int start_cyc;
        int busy_n;
        int n;
        bit seen;
        exp_q.push_back({er, fl(ef)});
        @(negedge clk);
        issue(op, av, bv);
        start_cyc = cyc;
        busy_n = 0;
        n = 0;
        seen = 0;
        while (!seen && n < 100) begin
            if (bus.busy) busy_n++;
            if (bus.done) seen = 1;
            if (disturb && n == 3) begin
                bus.start = 1'b1; bus.a = 32'h1234_5678; bus.b = 32'h0000_0FFF; bus.ALUControl = 2'b01;
            end
            if (disturb && n == 4) bus.start = 1'b0;
            if (disturb && n == 10) begin
                bus.a = 32'hDEAD_BEEF; bus.b = 32'h0BAD_F00D;
            end
            if (!seen) begin
                @(negedge clk);
                n++;
            end
        end
        check("done_seen", {63'h0, seen}, 64'h1);
        check("latency", 64'(cyc - start_cyc), 64'd33);
        check("busy_cycles", 64'(busy_n), 64'd32);
        @(negedge clk);
        check("done_one_cycle", {63'h0, bus.done}, 64'h0);
    endtask

    initial begin
        int base;
        checks = 0; fails = 0; cyc = 0; done_cnt = 0;
        reset = 1'b1;
        bus.start = 1'b0; bus.a = '0; bus.b = '0; bus.ALUControl = 2'b00;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check("rst_busy", {63'h0, bus.busy}, 64'h0);
        check("rst_done", {63'h0, bus.done}, 64'h0);
        check("rst_result", {32'h0, bus.Result}, 64'h0);
        check("rst_flags", {60'h0, bus.ALUFlags}, 64'h0);

        run_op(2'b00, 32'h7FFF_FFFF, 32'h0000_0001, 32'h8000_0000, 4'b1001, 0);
        run_op(2'b01, 32'd5, 32'd5, 32'h0000_0000, 4'b0110, 0);
        run_op(2'b01, 32'd3, 32'd5, 32'hFFFF_FFFE, 4'b1000, 0);
        run_op(2'b10, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'hF000_F000, 4'b1000, 0);
        run_op(2'b11, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'hFFF0_FFF0, 4'b1000, 0);
        run_op(2'b00, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 4'b0110, 0);

        // requests and input changes while busy must be ignored
        base = done_cnt;
        run_op(2'b00, 32'd1, 32'd1, 32'h0000_0002, 4'b0000, 1);
        repeat (40) @(negedge clk);
        check("single_done", 64'(done_cnt - base), 64'd1);
        check("held_result", {32'h0, bus.Result}, 64'h2);

        // reset mid-operation abandons the op
        base = done_cnt;
        issue(2'b01, 32'd0, 32'd1);
        repeat (14) @(negedge clk);
        check("mid_busy", {63'h0, bus.busy}, 64'h1);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("mrst_busy", {63'h0, bus.busy}, 64'h0);
        check("mrst_done", {63'h0, bus.done}, 64'h0);
        check("mrst_result", {32'h0, bus.Result}, 64'h0);
        check("mrst_flags", {60'h0, bus.ALUFlags}, 64'h0);
        repeat (40) @(negedge clk);
        check("no_done_after_rst", 64'(done_cnt - base), 64'd0);

        // reset and start in the same cycle: start dropped
        reset = 1'b1;
        bus.start = 1'b1; bus.a = 32'd7; bus.b = 32'd7; bus.ALUControl = 2'b00;
        @(negedge clk);
        reset = 1'b0;
        bus.start = 1'b0;
        @(negedge clk);
        check("rst_start_busy", {63'h0, bus.busy}, 64'h0);

        run_op(2'b00, 32'd2, 32'd3, 32'h0000_0005, 4'b0000, 0);
        repeat (5) @(negedge clk);
        check("queue_empty", 64'(exp_q.size()), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end
endmodule
